// File: rtl/prog_sequencer_pkg.sv
// Shared opcode map, sequencer state encoding and issue-flag helper for the
// 1-bit ICU front end; the ICU controller imports the same constants.
package prog_sequencer_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOPO = 4'h0;
    localparam opcode_t OP_LD   = 4'h1;
    localparam opcode_t OP_LDC  = 4'h2;
    localparam opcode_t OP_AND  = 4'h3;
    localparam opcode_t OP_ANDC = 4'h4;
    localparam opcode_t OP_OR   = 4'h5;
    localparam opcode_t OP_ORC  = 4'h6;
    localparam opcode_t OP_XNOR = 4'h7;
    localparam opcode_t OP_STO  = 4'h8;
    localparam opcode_t OP_STOC = 4'h9;
    localparam opcode_t OP_IEN  = 4'hA;
    localparam opcode_t OP_OEN  = 4'hB;
    localparam opcode_t OP_JMP  = 4'hC;
    localparam opcode_t OP_RTN  = 4'hD;
    localparam opcode_t OP_SKZ  = 4'hE;
    localparam opcode_t OP_NOPF = 4'hF;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        logic o;
        logic f;
        logic jmp;
        logic rtn;
    } flags_t;

    function automatic flags_t issue_flags(input opcode_t op);
        flags_t fl;
        fl     = '0;
        fl.o   = (op == OP_NOPO);
        fl.f   = (op == OP_NOPF);
        fl.jmp = (op == OP_JMP);
        fl.rtn = (op == OP_RTN);
        return fl;
    endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Program-memory fetch bus: req held until ack, addr stable while req is high,
// data = {opcode, jump target} valid only in the ack cycle.
interface prog_sequencer_if #(
    parameter int AW = 8
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [AW+3:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/prog_sequencer_ret_stack.sv
// Return-address LIFO, SD entries of AW bits; push/pop take effect on the next
// edge, dout shows the top entry combinationally; push when full / pop when empty are dropped.
module ret_stack #(
    parameter int AW = 8,
    parameter int SD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int IW = (SD > 1) ? $clog2(SD) : 1;
    localparam int CW = $clog2(SD + 1);

    logic [AW-1:0] entries [SD];
    logic [CW-1:0] cnt;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;

    assign wr_idx  = IW'(cnt);
    assign top_idx = IW'(cnt - CW'(1));
    assign full    = (cnt == CW'(SD));
    assign empty   = (cnt == '0);
    assign dout    = entries[top_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Storage needs no reset: an entry is only read after it has been pushed.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            entries[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Fetch/issue sequencer feeding the 1-bit ICU: one opcode per 2 cycles minimum, issue
// one cycle after mem_ack; fetch waits indefinitely for ack, no backpressure from the ICU.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int AW = 8,
    parameter int SD = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    prog_sequencer_if.master        mem,
    input  logic                    rr,
    output logic [3:0]              inst,
    output logic                    inst_valid,
    output logic                    flag_o,
    output logic                    flag_f,
    output logic                    flag_jmp,
    output logic                    flag_rtn,
    output logic                    stk_err
);

    state_t        state_q, state_nxt;
    logic [AW-1:0] pc_q, pc_nxt;
    logic [AW+3:0] ir_q, ir_nxt;
    logic          skip_q, skip_nxt;
    logic          req_q, req_nxt;
    logic [3:0]    inst_q, inst_nxt;
    logic          vld_q, vld_nxt;
    flags_t        flags_q, flags_nxt;
    logic          err_q, err_nxt;

    logic          push;
    logic          pop;
    logic [AW-1:0] stk_dout;
    logic          stk_full;
    logic          stk_empty;

    opcode_t       fetch_op;
    opcode_t       ir_op;
    logic [AW-1:0] ir_tgt;
    logic [AW-1:0] pc_inc;

    assign fetch_op = mem.mem_data[AW+3:AW];
    assign ir_op    = ir_q[AW+3:AW];
    assign ir_tgt   = ir_q[AW-1:0];
    assign pc_inc   = pc_q + AW'(1);

    ret_stack #(
        .AW (AW),
        .SD (SD)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Issue-cycle outputs are computed at the ack edge so the ICU sees a
    // registered opcode for the whole ISSUE cycle, including its falling edge.
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        ir_nxt    = ir_q;
        skip_nxt  = skip_q;
        req_nxt   = req_q;
        inst_nxt  = '0;
        vld_nxt   = 1'b0;
        flags_nxt = '0;
        err_nxt   = err_q;
        push      = 1'b0;
        pop       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (req_q && mem.mem_ack) begin
                    state_nxt = ST_ISSUE;
                    req_nxt   = 1'b0;
                    ir_nxt    = mem.mem_data;
                    vld_nxt   = 1'b1;
                    if (!skip_q) begin
                        inst_nxt  = fetch_op;
                        flags_nxt = issue_flags(fetch_op);
                    end
                end else begin
                    req_nxt = 1'b1;
                end
            end

            ST_ISSUE: begin
                state_nxt = ST_FETCH;
                req_nxt   = 1'b1;
                skip_nxt  = 1'b0;
                pc_nxt    = pc_inc;
                if (!skip_q) begin
                    case (ir_op)
                        OP_JMP: begin
                            pc_nxt = ir_tgt;
                            if (stk_full) begin
                                err_nxt = 1'b1;
                            end else begin
                                push = 1'b1;
                            end
                        end
                        OP_RTN: begin
                            skip_nxt = 1'b1;
                            if (stk_empty) begin
                                pc_nxt  = '0;
                                err_nxt = 1'b1;
                            end else begin
                                pop    = 1'b1;
                                pc_nxt = stk_dout;
                            end
                        end
                        OP_SKZ: begin
                            skip_nxt = ~rr;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            skip_q  <= 1'b0;
            req_q   <= 1'b0;
            inst_q  <= '0;
            vld_q   <= 1'b0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            ir_q    <= ir_nxt;
            skip_q  <= skip_nxt;
            req_q   <= req_nxt;
            inst_q  <= inst_nxt;
            vld_q   <= vld_nxt;
            flags_q <= flags_nxt;
            err_q   <= err_nxt;
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = pc_q;
    assign inst         = inst_q;
    assign inst_valid   = vld_q;
    assign flag_o       = flags_q.o;
    assign flag_f       = flags_q.f;
    assign flag_jmp     = flags_q.jmp;
    assign flag_rtn     = flags_q.rtn;
    assign stk_err      = err_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: program-memory responder, ISA-level reference
// interpreter checked on every cycle, plus literal expectations per scenario.
module tb_prog_sequencer;
    import prog_sequencer_pkg::*;

    localparam int AW = 8;
    localparam int SD = 4;

    logic       clk;
    logic       rst;
    logic       rr;
    logic [3:0] inst;
    logic       inst_valid;
    logic       flag_o;
    logic       flag_f;
    logic       flag_jmp;
    logic       flag_rtn;
    logic       stk_err;

    prog_sequencer_if #(.AW(AW)) mem_bus ();

    prog_sequencer #(.AW(AW), .SD(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (mem_bus),
        .rr         (rr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .flag_o     (flag_o),
        .flag_f     (flag_f),
        .flag_jmp   (flag_jmp),
        .flag_rtn   (flag_rtn),
        .stk_err    (stk_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [11:0] prog [256];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    bit          force_ack = 1'b0;
    logic [7:0]  acked [$];

    int          n_issued   = 0;
    int          cyc        = 0;
    int          last_issue = -1;
    logic [7:0]  log_addr [$];
    logic [3:0]  log_inst [$];
    logic [3:0]  log_flag [$];

    // Architectural reference state
    logic [7:0]  m_pc;
    bit          m_skip;
    bit          m_err;
    logic [7:0]  m_stk [$];

    int e5_addr [16] = '{'h00, 'h10, 'h20, 'h30, 'h40, 'h50, 'h31, 'h32,
                         'h21, 'h22, 'h11, 'h12, 'h01, 'h02, 'h00, 'h01};
    int e5_inst [16] = '{12, 12, 12, 12, 12, 13, 0, 13, 0, 13, 0, 13, 0, 13, 0, 1};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_log(input string tag, input int idx, input int a, input int op, input int fl);
        chk($sformatf("%s entry%0d present", tag, idx), int'(idx < log_inst.size()), 1);
        if (idx < log_inst.size() && idx < log_addr.size()) begin
            chk($sformatf("%s addr%0d", tag, idx), int'(log_addr[idx]), a);
            chk($sformatf("%s inst%0d", tag, idx), int'(log_inst[idx]), op);
            chk($sformatf("%s flags%0d", tag, idx), int'(log_flag[idx]), fl);
        end
    endtask

    // Memory responder: acks after ack_delay wait cycles, or at once when forced.
    always @(posedge clk) begin
        #2;
        if (mem_bus.mem_req && (force_ack || wait_cnt >= ack_delay)) begin
            mem_bus.mem_ack  = 1'b1;
            mem_bus.mem_data = prog[mem_bus.mem_addr];
            wait_cnt         = 0;
            if (!rst) acked.push_back(mem_bus.mem_addr);
        end else begin
            mem_bus.mem_ack  = 1'b0;
            mem_bus.mem_data = '0;
            wait_cnt         = mem_bus.mem_req ? wait_cnt + 1 : 0;
        end
    end

    // Per-cycle comparison against the instruction-level interpreter.
    always @(negedge clk) begin
        logic [3:0] op;
        logic [7:0] tg;
        logic [7:0] a;
        logic [3:0] e_inst;
        logic [3:0] e_fl;
        logic [3:0] act_fl;
        cyc++;
        act_fl = {flag_o, flag_f, flag_jmp, flag_rtn};
        if (rst) begin
            m_pc   = '0;
            m_skip = 1'b0;
            m_err  = 1'b0;
            m_stk.delete();
            acked.delete();
            last_issue = -1;
        end else if (inst_valid) begin
            op = prog[m_pc][11:8];
            tg = prog[m_pc][7:0];
            chk("fetch before issue", int'(acked.size() > 0), 1);
            if (acked.size() > 0) begin
                a = acked.pop_front();
                chk("fetch addr", int'(a), int'(m_pc));
                log_addr.push_back(a);
            end
            e_inst = m_skip ? 4'h0 : op;
            e_fl   = m_skip ? 4'h0 : {op == OP_NOPO, op == OP_NOPF, op == OP_JMP, op == OP_RTN};
            chk("issue inst", int'(inst), int'(e_inst));
            chk("issue flags", int'(act_fl), int'(e_fl));
            chk("issue stk_err", int'(stk_err), int'(m_err));
            if (ack_delay == 0 && last_issue >= 0) chk("issue spacing", cyc - last_issue, 2);
            last_issue = cyc;
            log_inst.push_back(inst);
            log_flag.push_back(act_fl);
            if (m_skip) begin
                m_skip = 1'b0;
                m_pc   = m_pc + 8'd1;
            end else begin
                case (op)
                    OP_JMP: begin
                        if (m_stk.size() < SD) m_stk.push_back(m_pc + 8'd1);
                        else m_err = 1'b1;
                        m_pc = tg;
                    end
                    OP_RTN: begin
                        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                        else begin
                            m_pc  = '0;
                            m_err = 1'b1;
                        end
                        m_skip = 1'b1;
                    end
                    OP_SKZ: begin
                        m_skip = !rr;
                        m_pc   = m_pc + 8'd1;
                    end
                    default: m_pc = m_pc + 8'd1;
                endcase
            end
            n_issued++;
        end else begin
            chk("idle inst", int'(inst), 0);
            chk("idle flags", int'(act_fl), 0);
            chk("idle stk_err", int'(stk_err), int'(m_err));
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 12'h100;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " mem_req"}, int'(mem_bus.mem_req), 0);
        chk({tag, " mem_addr"}, int'(mem_bus.mem_addr), 0);
        chk({tag, " inst"}, int'(inst), 0);
        chk({tag, " inst_valid"}, int'(inst_valid), 0);
        chk({tag, " flags"}, int'({flag_o, flag_f, flag_jmp, flag_rtn}), 0);
        chk({tag, " stk_err"}, int'(stk_err), 0);
    endtask

    // Called just after a rising edge; leaves rst low, again just after a rising edge.
    task automatic apply_reset(input string tag);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state(tag);
        n_issued = 0;
        log_addr.delete();
        log_inst.delete();
        log_flag.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        force_ack = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        apply_reset(tag);
    endtask

    task automatic run_issues(input int target, input int budget);
        int n;
        n = 0;
        while (n_issued < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("issue count reached %0d", target), int'(n_issued >= target), 1);
    endtask

    initial begin
        int  cnt;
        int  bad_addr;
        bit  seen;
        rst = 1'b1;
        rr  = 1'b0;
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_data = '0;
        clear_prog();

        // Straight-line LD, AND, STO at full rate
        prog[0] = 12'h100; prog[1] = 12'h300; prog[2] = 12'h800;
        do_reset("t1 reset");
        run_issues(3, 40);
        check_log("t1", 0, 'h00, 1, 0);
        check_log("t1", 1, 'h01, 3, 0);
        check_log("t1", 2, 'h02, 8, 0);

        // Three wait cycles on the first fetch
        do_reset("t2 reset");
        ack_delay = 3;
        cnt = 0; bad_addr = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (inst_valid) seen = 1'b1;
            else if (mem_bus.mem_req) begin
                cnt++;
                if (mem_bus.mem_addr != 8'h00) bad_addr++;
            end
        end
        chk("t2 issue seen", int'(seen), 1);
        chk("t2 req cycles", cnt, 4);
        chk("t2 addr changes", bad_addr, 0);
        run_issues(1, 10);
        check_log("t2", 0, 'h00, 1, 0);

        // JMP then RTN: return squashes the instruction after the call
        clear_prog();
        prog[0] = 12'hC20; prog['h20] = 12'hD00; prog[1] = 12'h500; prog[2] = 12'h100;
        do_reset("t3 reset");
        ack_delay = 0;
        run_issues(4, 40);
        check_log("t3", 0, 'h00, 'hC, 2);
        check_log("t3", 1, 'h20, 'hD, 1);
        check_log("t3", 2, 'h01, 0, 0);
        check_log("t3", 3, 'h02, 1, 0);

        // SKZ with rr=0 then rr=1; NOPO/NOPF flags; one wait cycle per fetch
        clear_prog();
        prog[0] = 12'hE00; prog[1] = 12'h000; prog[2] = 12'hE00; prog[3] = 12'hF00; prog[4] = 12'h000;
        do_reset("t4 reset");
        ack_delay = 1;
        rr = 1'b0;
        run_issues(2, 40);
        rr = 1'b1;
        run_issues(5, 60);
        check_log("t4", 0, 'h00, 'hE, 0);
        check_log("t4", 1, 'h01, 0, 0);
        check_log("t4", 2, 'h02, 'hE, 0);
        check_log("t4", 3, 'h03, 'hF, 4);
        check_log("t4", 4, 'h04, 0, 8);
        rr = 1'b0;

        // Five nested JMPs overflow the 4-deep stack, then unwind to underflow
        clear_prog();
        prog['h00] = 12'hC10; prog['h10] = 12'hC20; prog['h20] = 12'hC30;
        prog['h30] = 12'hC40; prog['h40] = 12'hC50;
        prog['h50] = 12'hD00; prog['h32] = 12'hD00; prog['h22] = 12'hD00;
        prog['h12] = 12'hD00; prog['h02] = 12'hD00;
        do_reset("t5 reset");
        ack_delay = 0;
        run_issues(16, 120);
        for (int i = 0; i < 16; i++)
            check_log("t5", i, e5_addr[i], e5_inst[i],
                      (e5_inst[i] == 12) ? 2 : (e5_inst[i] == 13) ? 1 : 0);
        @(negedge clk);
        chk("t5 stk_err sticky", int'(stk_err), 1);

        // pc wraps from 0xFF to 0x00
        clear_prog();
        prog['h00] = 12'hCFF; prog['hFF] = 12'h100;
        do_reset("t6 reset");
        run_issues(3, 40);
        check_log("t6", 0, 'h00, 'hC, 2);
        check_log("t6", 1, 'hFF, 1, 0);
        check_log("t6", 2, 'h00, 'hC, 2);
        @(negedge clk);
        chk("t6 stk_err", int'(stk_err), 0);

        // Reset mid-fetch with an ack in the same cycle, stack holding two entries
        clear_prog();
        prog['h00] = 12'hC10; prog['h10] = 12'hC20; prog['h20] = 12'h100;
        do_reset("t7 reset");
        run_issues(2, 40);
        ack_delay = 10;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (mem_bus.mem_req) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("t7 req before rst", int'(seen), 1);
        force_ack = 1'b1;
        apply_reset("t7 rst in fetch");
        clear_prog();
        prog['h00] = 12'hD00;
        ack_delay = 0;
        run_issues(3, 40);
        check_log("t7", 0, 'h00, 'hD, 1);
        check_log("t7", 1, 'h00, 0, 0);
        check_log("t7", 2, 'h01, 1, 0);
        @(negedge clk);
        chk("t7 underflow after reset", int'(stk_err), 1);

        // Reset landing in an ISSUE cycle
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (inst_valid) seen = 1'b1;
        end
        chk("t8 issue found", int'(seen), 1);
        apply_reset("t8 rst in issue");
        run_issues(2, 40);
        check_log("t8", 0, 'h00, 'hD, 1);
        check_log("t8", 1, 'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Instruction fetch and sequencing stage directly upstream of the 1-bit ICU. It holds the program counter, fetches 4-bit-opcode + address words from program memory over a req/ack handshake, and presents one opcode per issue cycle on the ICU instruction input. It also executes the flow-control opcodes locally:
- JMP (C): jump, pushing a return address.
- RTN (D): return, then skip the next instruction.
- SKZ (E): skip the next instruction when the result register is 0.
- NOPO (0) / NOPF (F): pulse the external flags.

Parameters:
AW, 8, program counter / memory address width
SD, 4, return stack depth (entries of AW bits)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
mem_req  out  1  fetch request; held high until mem_ack
mem_addr  out  AW  fetch address (= pc); stable while mem_req=1
mem_ack  in  1  memory has valid mem_data this cycle
mem_data  in  4+AW  [AW+3:AW] opcode, [AW-1:0] jump target
rr  in  1  ICU result register, sampled in ISSUE
inst  out  4  opcode to ICU; 4'h0 when not issuing or when squashed
inst_valid  out  1  high for exactly the ISSUE cycle
flag_o  out  1  one-cycle pulse on issued NOPO
flag_f  out  1  one-cycle pulse on issued NOPF
flag_jmp  out  1  one-cycle pulse on issued JMP
flag_rtn  out  1  one-cycle pulse on issued RTN
stk_err  out  1  sticky: stack overflow or underflow occurred; cleared only by rst

Behaviour:
- Reset values: pc=0, state=FETCH, mem_req=0, mem_addr=0, inst=0, inst_valid=0, all flags=0, stk_err=0, stack empty, skip=0.
- The ICU latches inst on the falling edge inside the ISSUE cycle, so inst must be registered and stable for that whole cycle.
- FETCH state:
  - mem_req=1 and mem_addr=pc, from the first cycle after entering FETCH.
  - On a cycle with mem_ack=1, latch mem_data into ir and go to ISSUE.
  - mem_req deasserts in the same edge.
  - Any number of wait cycles is legal.
- ISSUE state (1 cycle), then back to FETCH:
  - If skip=1: inst=0 (NOPO encoding), no flag pulses, no flow action, skip<=0, pc<=pc+1.
  - Otherwise inst=ir opcode, inst_valid=1, and the opcode acts as follows.
  - JMP (C): push pc+1; pc<=target; flag_jmp=1.
  - RTN (D): pc<=pop; skip<=1; flag_rtn=1.
  - SKZ (E): skip<=(rr==0); pc<=pc+1.
  - NOPO (0) / NOPF (F): flag_o / flag_f =1; pc<=pc+1.
  - All other opcodes: pc<=pc+1.
- Minimum throughput: 1 instruction per 2 cycles (ack in first FETCH cycle). Latency from mem_ack edge to inst_valid is 1 cycle.
- pc arithmetic is modulo 2^AW (pc=2^AW-1 increments to 0). The pushed pc+1 wraps the same way.
- Stack overflow (push with SD entries): push discarded, target still taken, stk_err<=1.
- Stack underflow (pop when empty): pc<=0, skip still set, stk_err<=1.
- Squashed instructions never touch the stack, pc target, or flags.
- rst asserted in any state (including mid-fetch with mem_req=1) forces the reset values on that edge. A mem_ack arriving in the same cycle as rst is ignored.
- mem_ack while in ISSUE or with mem_req=0 is ignored.

Decomposition:
- Shared package, constants for the 16 opcodes: OP_NOPO=0, OP_LD=1, OP_LDC=2, OP_AND=3, OP_ANDC=4, OP_OR=5, OP_ORC=6, OP_XNOR=7, OP_STO=8, OP_STOC=9, OP_IEN=A, OP_OEN=B, OP_JMP=C, OP_RTN=D, OP_SKZ=E, OP_NOPF=F.
- The package also holds the state encoding FETCH/ISSUE. The ICU controller reuses these constants.
- Sub-module ret_stack (parameters AW, SD):
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty.
  - Synchronous reset to empty.
  - push and pop are never asserted together.

Test Plan:
- Reset, then program 0:LD, 1:AND, 2:STO with ack in the first FETCH cycle -> mem_addr 0,1,2; inst 1,3,8, each with inst_valid every 2nd cycle; no flags.
- Ack delayed 3 cycles at addr 0 -> mem_req held high 4 cycles, mem_addr steady at 0; inst_valid only after ack.
- 0:JMP 0x20, 0x20:RTN, 1:OR, 2:LD -> flag_jmp, fetch 0x20, flag_rtn, addr 1 fetched with inst=0 (squashed), then addr 2 issues inst=1.
- SKZ with rr=0, then SKZ with rr=1 -> first following instruction squashed (inst=0, no flag); second issued normally.
- SD=4: five nested JMPs -> 5th sets stk_err; RTN on empty stack -> pc=0, stk_err stays 1. AW=8 with pc=0xFF -> next fetch addr 0x00.
- rst asserted while mem_req=1 and again in ISSUE -> next cycle mem_req=0, inst=0, flags 0, stack empty; subsequent fetch starts at addr 0.
